// File: rtl/dili_decode_seq_if.sv
// dili_decode_seq_if: sequencer <-> Dilithium coefficient decoder link.
// Carries decoder control and configuration, the packed-word handshake and the
// sample-group handshake. Member names follow the sequencer's point of view.
interface dili_decode_seq_if #(
  parameter int unsigned pW        = 64,
  parameter int unsigned pOUTPUT_W = 4,
  parameter int unsigned pCOEFF_W  = 23
) ();
  logic                          dec_rst_o;
  logic [2:0]                    dec_sec_lvl_o;
  logic [2:0]                    dec_encode_mode_o;
  logic [pW-1:0]                 dec_di_o;
  logic                          dec_in_valid_o;
  logic                          dec_in_ready_i;
  logic [pOUTPUT_W*pCOEFF_W-1:0] dec_samples_i;
  logic                          dec_out_valid_i;
  logic                          dec_out_ready_o;

  // Sequencer side
  modport master (
    output dec_rst_o, dec_sec_lvl_o, dec_encode_mode_o, dec_di_o, dec_in_valid_o,
           dec_out_ready_o,
    input  dec_in_ready_i, dec_samples_i, dec_out_valid_i
  );

  // Decoder side
  modport slave (
    input  dec_rst_o, dec_sec_lvl_o, dec_encode_mode_o, dec_di_o, dec_in_valid_o,
           dec_out_ready_o,
    output dec_in_ready_i, dec_samples_i, dec_out_valid_i
  );
endinterface

// File: rtl/dili_decode_seq.sv
// dili_decode_seq: buffers host packed words into the Dilithium decoder, collects decoded
// sample groups into a readback FIFO and ends the job after n_poly polynomials.
// Optional feature macro: DILI_DECODE_SEQ_TIMEOUT_EN -- abort after pTIMEOUT consecutive
// handshake-free RUN cycles. Without it RUN waits indefinitely.
module dili_decode_seq #(
  parameter int unsigned pW         = 64,
  parameter int unsigned pOUTPUT_W  = 4,
  parameter int unsigned pCOEFF_W   = 23,
  parameter int unsigned pIN_DEPTH  = 8,
  parameter int unsigned pOUT_DEPTH = 8,
  parameter int unsigned pTIMEOUT   = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [2:0]                    sec_lvl_i,
  input  logic [2:0]                    encode_mode_i,
  input  logic [3:0]                    n_poly_i,
  input  logic                          in_wr_i,
  input  logic [pW-1:0]                 in_data_i,
  output logic                          in_full_o,
  input  logic                          out_rd_i,
  output logic [pOUTPUT_W*pCOEFF_W-1:0] out_data_o,
  output logic                          out_empty_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  dili_decode_seq_if.master             dec_if
);
  localparam int unsigned DW     = pOUTPUT_W * pCOEFF_W;
  localparam int unsigned GRP_AW = $clog2(256 / pOUTPUT_W);
  localparam int unsigned CNT_W  = 4 + GRP_AW;
  localparam int unsigned IN_AW  = $clog2(pIN_DEPTH);
  localparam int unsigned IN_CW  = IN_AW + 1;
  localparam int unsigned OUT_AW = $clog2(pOUT_DEPTH);
  localparam int unsigned OUT_CW = OUT_AW + 1;

  // Elaboration-time parameter sanity
  if ((256 % pOUTPUT_W) != 0) begin : g_bad_output_w
    $error("pOUTPUT_W must divide 256");
  end
  if (pIN_DEPTH < 2 || (pIN_DEPTH & (pIN_DEPTH - 1)) != 0) begin : g_bad_in_depth
    $error("pIN_DEPTH must be a power of 2, at least 2");
  end
  if (pOUT_DEPTH < 2 || (pOUT_DEPTH & (pOUT_DEPTH - 1)) != 0) begin : g_bad_out_depth
    $error("pOUT_DEPTH must be a power of 2, at least 2");
  end
  if (pTIMEOUT < 2) begin : g_bad_timeout
    $error("pTIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StCfg, StRun, StDone} state_e;

  state_e r_state, w_state_d;

  logic             r_dec_rst, w_dec_rst_d;
  logic             r_err, w_err_d;
  logic [2:0]       r_sec_lvl, r_encode_mode;
  logic [3:0]       r_n_poly;
  logic [CNT_W-1:0] r_grp, w_grp_d, w_grp_inc, w_target;

  logic w_abort, w_timeout, w_start;

  // Input word FIFO
  logic [pW-1:0]    r_in_mem [pIN_DEPTH];
  logic [IN_AW-1:0] r_in_wr, r_in_rd, w_in_wr_d, w_in_rd_d, w_in_waddr;
  logic [IN_CW-1:0] r_in_cnt, w_in_cnt_d;
  logic             w_in_empty, w_in_full, w_in_push, w_in_pop, w_in_flush, w_in_drop;
  logic             w_dec_in_valid;

  // Output group FIFO
  logic [DW-1:0]     r_out_mem [pOUT_DEPTH];
  logic [OUT_AW-1:0] r_out_wr, r_out_rd, w_out_wr_d, w_out_rd_d;
  logic [OUT_CW-1:0] r_out_cnt, w_out_cnt_d;
  logic              w_out_empty, w_out_full, w_out_push, w_out_pop;
  logic              w_dec_out_ready;

  assign w_abort = abort_i || w_timeout;
  assign w_start = start_i && !w_abort && (r_state == StIdle);

  assign w_in_empty     = (r_in_cnt == '0);
  assign w_in_full      = (r_in_cnt == IN_CW'(pIN_DEPTH));
  assign w_dec_in_valid = (r_state == StRun) && !w_in_empty;
  assign w_in_pop       = w_dec_in_valid && dec_if.dec_in_ready_i;
  assign w_in_flush     = w_start || w_abort;
  // A flush empties the FIFO first, so a same-cycle write always lands
  assign w_in_push      = in_wr_i && (w_in_flush || !w_in_full || w_in_pop);
  assign w_in_drop      = in_wr_i && !w_in_push;
  assign w_in_waddr     = w_in_flush ? '0 : r_in_wr;

  assign w_out_empty     = (r_out_cnt == '0);
  assign w_out_full      = (r_out_cnt == OUT_CW'(pOUT_DEPTH));
  assign w_dec_out_ready = (r_state == StRun) && !w_out_full;
  assign w_out_push      = dec_if.dec_out_valid_i && w_dec_out_ready;
  assign w_out_pop       = out_rd_i && !w_out_empty;

  assign w_grp_inc = r_grp + CNT_W'(1);
  assign w_target  = CNT_W'(r_n_poly) << GRP_AW;

`ifdef DILI_DECODE_SEQ_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(pTIMEOUT + 1);

  logic [STALL_W-1:0] r_stall, w_stall_d;
  logic               w_stall_cyc;

  assign w_stall_cyc = (r_state == StRun) && !w_in_pop && !w_out_push;
  assign w_timeout   = w_stall_cyc && (r_stall == STALL_W'(pTIMEOUT - 1));

  // Count consecutive RUN cycles without any decoder handshake
  always_comb begin
    w_stall_d = '0;
    if (w_stall_cyc && !w_timeout) w_stall_d = r_stall + STALL_W'(1);
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (rst) r_stall <= '0;
    else     r_stall <= w_stall_d;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next state, decoder reset, sticky error and group counter
  always_comb begin
    w_state_d = r_state;
    w_grp_d   = r_grp;
    w_err_d   = r_err;
    unique case (r_state)
      StIdle: if (w_start) w_state_d = StCfg;
      StCfg:  w_state_d = (r_n_poly == 4'd0) ? StDone : StRun;
      StRun: begin
        if (w_out_push) begin
          w_grp_d = w_grp_inc;
          // Terminal compare precedes any further increment, so the counter never wraps
          if (w_grp_inc == w_target) w_state_d = StDone;
        end
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (w_start) w_grp_d = '0;
    if (w_abort) w_state_d = StIdle;

    // Decoder is held in reset during CFG and for the cycle after an abort
    w_dec_rst_d = w_abort || (w_state_d == StCfg);

    if (w_start) w_err_d = 1'b0;
    if (w_abort || w_in_drop || ((r_state == StCfg) && (r_n_poly == 4'd0))) w_err_d = 1'b1;
  end

  // Input FIFO pointer/count next state
  always_comb begin
    w_in_wr_d  = r_in_wr;
    w_in_rd_d  = r_in_rd;
    w_in_cnt_d = r_in_cnt;
    if (w_in_flush) begin
      w_in_rd_d  = '0;
      w_in_wr_d  = w_in_push ? IN_AW'(1) : '0;
      w_in_cnt_d = w_in_push ? IN_CW'(1) : '0;
    end else begin
      if (w_in_push) w_in_wr_d = r_in_wr + IN_AW'(1);
      if (w_in_pop)  w_in_rd_d = r_in_rd + IN_AW'(1);
      w_in_cnt_d = r_in_cnt + IN_CW'(w_in_push) - IN_CW'(w_in_pop);
    end
  end

  // Output FIFO pointer/count next state; only a new start flushes it
  always_comb begin
    w_out_wr_d  = r_out_wr;
    w_out_rd_d  = r_out_rd;
    w_out_cnt_d = r_out_cnt;
    if (w_start) begin
      w_out_wr_d  = '0;
      w_out_rd_d  = '0;
      w_out_cnt_d = '0;
    end else begin
      if (w_out_push) w_out_wr_d = r_out_wr + OUT_AW'(1);
      if (w_out_pop)  w_out_rd_d = r_out_rd + OUT_AW'(1);
      w_out_cnt_d = r_out_cnt + OUT_CW'(w_out_push) - OUT_CW'(w_out_pop);
    end
  end

  // Control and FIFO pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_dec_rst     <= 1'b1;
      r_err         <= 1'b0;
      r_sec_lvl     <= '0;
      r_encode_mode <= '0;
      r_n_poly      <= '0;
      r_grp         <= '0;
      r_in_wr       <= '0;
      r_in_rd       <= '0;
      r_in_cnt      <= '0;
      r_out_wr      <= '0;
      r_out_rd      <= '0;
      r_out_cnt     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_dec_rst <= w_dec_rst_d;
      r_err     <= w_err_d;
      r_grp     <= w_grp_d;
      r_in_wr   <= w_in_wr_d;
      r_in_rd   <= w_in_rd_d;
      r_in_cnt  <= w_in_cnt_d;
      r_out_wr  <= w_out_wr_d;
      r_out_rd  <= w_out_rd_d;
      r_out_cnt <= w_out_cnt_d;
      if (w_start) begin
        r_sec_lvl     <= sec_lvl_i;
        r_encode_mode <= encode_mode_i;
        r_n_poly      <= n_poly_i;
      end
    end
  end

  // FIFO storage; contents are only observable through the non-empty heads
  always_ff @(posedge clk) begin
    if (w_in_push)  r_in_mem[w_in_waddr] <= in_data_i;
    if (w_out_push) r_out_mem[r_out_wr]  <= dec_if.dec_samples_i;
  end

  assign in_full_o   = w_in_full;
  assign out_empty_o = w_out_empty;
  assign out_data_o  = w_out_empty ? '0 : r_out_mem[r_out_rd];
  assign busy_o      = (r_state == StCfg) || (r_state == StRun);
  assign done_o      = (r_state == StDone);
  assign err_o       = r_err;

  assign dec_if.dec_rst_o         = r_dec_rst;
  assign dec_if.dec_sec_lvl_o     = r_sec_lvl;
  assign dec_if.dec_encode_mode_o = r_encode_mode;
  assign dec_if.dec_di_o          = w_in_empty ? '0 : r_in_mem[r_in_rd];
  assign dec_if.dec_in_valid_o    = w_dec_in_valid;
  assign dec_if.dec_out_ready_o   = w_dec_out_ready;
endmodule
